// File: rtl/hex_disp_pkg.sv
// Shared types, segment constants and the 0-F glyph encoder for the seven-segment controller.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package hex_disp_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK = 7'h7F;
    localparam seg7_t SEG_MINUS = 7'h3F;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_FORMAT = 2'd2
    } state_t;

    function automatic seg7_t seg7_enc(input logic [3:0] v);
        seg7_t s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: one input bit per cycle into an N_DIGITS BCD register.
// o_done pulses one cycle after the last shift; o_overflow is sticky for that conversion.
module bin2bcd_seq #(
    parameter int DATA_W   = 20,
    parameter int N_DIGITS = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [DATA_W-1:0]     i_bin,
    output logic [4*N_DIGITS-1:0] o_bcd,
    output logic                  o_done,
    output logic                  o_overflow
);

    localparam int BCD_W = 4 * N_DIGITS;
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [BCD_W-1:0]  bcd_q, bcd_d, adj;
    logic [DATA_W-1:0] bin_q, bin_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;

    always_comb begin
        adj = bcd_q;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
        end

        bcd_d  = bcd_q;
        bin_d  = bin_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        ovf_d  = ovf_q;
        done_d = 1'b0;

        if (i_start) begin
            bcd_d  = '0;
            bin_d  = i_bin;
            cnt_d  = CNT_W'(DATA_W);
            busy_d = 1'b1;
            ovf_d  = 1'b0;
        end else if (busy_q) begin
            // Whatever leaves the top digit is a value that needs one more digit.
            bcd_d = {adj[BCD_W-2:0], bin_q[DATA_W-1]};
            bin_d = bin_q << 1;
            ovf_d = ovf_q | adj[BCD_W-1];
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bcd_q  <= '0;
            bin_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            bcd_q  <= bcd_d;
            bin_q  <= bin_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
            ovf_q  <= ovf_d;
        end
    end

    assign o_bcd      = bcd_q;
    assign o_done     = done_q;
    assign o_overflow = ovf_q;

endmodule

// File: rtl/hex_display_ctrl.sv
// Seven-segment display controller: valid/ready value intake, decimal or hex conversion,
// leading-zero blanking, sign, overflow dashes and a registered blink mux on o_hex.
module hex_display_ctrl
    import hex_disp_pkg::*;
#(
    parameter int N_DIGITS  = 6,
    parameter int DATA_W    = 20,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_W-1:0]     i_data,
    input  logic                  i_signed,
    input  logic                  i_hex_mode,
    input  logic                  i_blank_lz,
    input  logic                  i_blink_en,
    output logic [7*N_DIGITS-1:0] o_hex,
    output logic                  o_overflow
);

    localparam int HEX_W = 7 * N_DIGITS;
    localparam int EXT_W = 4 * N_DIGITS + DATA_W;
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    state_t                  state_q, state_d;
    logic [DATA_W-1:0]       data_q, data_d;
    logic                    hex_q, hex_d, lz_q, lz_d, neg_q, neg_d;
    logic [HEX_W-1:0]        stored_q, stored_d, o_hex_q, o_hex_d, seg_fmt;
    logic                    ovf_q, ovf_d, fmt_ovf, hex_ovf;
    logic [BLK_W-1:0]        blk_cnt_q;
    logic                    phase_q;

    logic                    accept, neg_in, bcd_start, bcd_done, bcd_ovf;
    logic [DATA_W-1:0]       mag;
    logic [4*N_DIGITS-1:0]   bcd;
    logic [EXT_W-1:0]        ext;
    logic [3:0]              dig [N_DIGITS];
    int                      hi, minus_pos;

    // o_ready is high exactly in IDLE; a beat is taken when i_valid && o_ready.
    assign o_ready   = (state_q == ST_IDLE);
    assign accept    = i_valid && o_ready;
    assign neg_in    = i_signed && i_data[DATA_W-1] && !i_hex_mode;
    assign mag       = neg_in ? (~i_data + 1'b1) : i_data;
    assign bcd_start = accept && !i_hex_mode;

    bin2bcd_seq #(.DATA_W(DATA_W), .N_DIGITS(N_DIGITS)) u_bin2bcd (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (bcd_start),
        .i_bin      (mag),
        .o_bcd      (bcd),
        .o_done     (bcd_done),
        .o_overflow (bcd_ovf)
    );

    assign ext     = EXT_W'(data_q);
    assign hex_ovf = |ext[EXT_W-1:4*N_DIGITS];

    always_comb begin
        hi = 0;
        for (int k = 0; k < N_DIGITS; k++) begin
            dig[k] = hex_q ? ext[4*k +: 4] : bcd[4*k +: 4];
            if (dig[k] != 4'd0) hi = k;
        end
        minus_pos = lz_q ? hi + 1 : N_DIGITS - 1;

        // A minus sign needs a free digit above the highest significant one.
        fmt_ovf = hex_q ? hex_ovf : bcd_ovf;
        if (neg_q && (hi >= N_DIGITS - 1)) fmt_ovf = 1'b1;

        seg_fmt = '1;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (fmt_ovf)                   seg_fmt[7*k +: 7] = SEG_MINUS;
            else if (neg_q && k == minus_pos) seg_fmt[7*k +: 7] = SEG_MINUS;
            else if (lz_q && k > hi)       seg_fmt[7*k +: 7] = SEG_BLANK;
            else                           seg_fmt[7*k +: 7] = seg7_enc(dig[k]);
        end
    end

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        hex_d    = hex_q;
        lz_d     = lz_q;
        neg_d    = neg_q;
        stored_d = stored_q;
        ovf_d    = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_CONV;
                    data_d  = i_data;
                    hex_d   = i_hex_mode;
                    lz_d    = i_blank_lz;
                    neg_d   = neg_in;
                end
            end
            ST_CONV: begin
                if (hex_q || bcd_done) state_d = ST_FORMAT;
            end
            ST_FORMAT: begin
                stored_d = seg_fmt;
                ovf_d    = fmt_ovf;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // New patterns reach o_hex on the FORMAT edge; blink follows phase one cycle late.
        o_hex_d = (i_blink_en && phase_q) ? '1 : stored_d;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            data_q    <= '0;
            hex_q     <= 1'b0;
            lz_q      <= 1'b0;
            neg_q     <= 1'b0;
            stored_q  <= '1;
            ovf_q     <= 1'b0;
            o_hex_q   <= '1;
            blk_cnt_q <= '0;
            phase_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            hex_q    <= hex_d;
            lz_q     <= lz_d;
            neg_q    <= neg_d;
            stored_q <= stored_d;
            ovf_q    <= ovf_d;
            o_hex_q  <= o_hex_d;
            if (blk_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
                blk_cnt_q <= '0;
                phase_q   <= ~phase_q;
            end else begin
                blk_cnt_q <= blk_cnt_q + 1'b1;
            end
        end
    end

    assign o_hex      = o_hex_q;
    assign o_overflow = ovf_q;

endmodule
